// File: rtl/ss_descale.sv
// Streaming descale: rounded arithmetic right shift per 8-sample block, 2-stage pipeline.
// Define SS_DESCALE_SAT_EN to saturate to OUT_WIDTH (otherwise the result wraps and out_sat stays 0).
module ss_descale #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_SHIFT = 7,
  parameter int BLOCK_LEN = 8,
  localparam int SHW      = $clog2(MAX_SHIFT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]       in_shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 out_sat
);

  localparam int IDXW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  logic                  adv;
  logic                  acc;
  logic [IDXW-1:0]       idx;
  logic [SHW-1:0]        shift_reg;
  logic [SHW-1:0]        shift_clamped;
  logic [SHW-1:0]        cur_shift;
  logic                  last_c;
  logic signed [IN_WIDTH:0] xe;
  logic signed [IN_WIDTH:0] rnd;
  logic signed [IN_WIDTH:0] t;

  logic                  s1_valid;
  logic signed [IN_WIDTH:0] s1_data;
  logic                  s1_last;

  logic [OUT_WIDTH-1:0]  conv;
  logic                  conv_sat;

  // One enable for the whole pipeline; a stalled output freezes everything.
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;
  assign acc      = in_valid && adv;

  // The first sample of a block bypasses shift_reg and uses the clamped input directly.
  always_comb begin
    shift_clamped = (in_shift > SHW'(MAX_SHIFT)) ? SHW'(MAX_SHIFT) : in_shift;
    cur_shift     = (idx == '0) ? shift_clamped : shift_reg;
    last_c        = (idx == IDXW'(BLOCK_LEN - 1));
    xe            = {in_data[IN_WIDTH-1], in_data};
    rnd           = '0;
    if (cur_shift != '0) begin
      rnd = (IN_WIDTH + 1)'(1) << (cur_shift - SHW'(1));
    end
    t = (xe + rnd) >>> cur_shift;
  end

`ifdef SS_DESCALE_SAT_EN
  localparam logic signed [IN_WIDTH:0] SAT_HI =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_LO =
    {{(IN_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  always_comb begin
    conv     = s1_data[OUT_WIDTH-1:0];
    conv_sat = 1'b0;
    if (s1_data > SAT_HI) begin
      conv     = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      conv_sat = 1'b1;
    end else if (s1_data < SAT_LO) begin
      conv     = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      conv_sat = 1'b1;
    end
  end
`else
  always_comb begin
    conv     = s1_data[OUT_WIDTH-1:0];
    conv_sat = 1'b0;
  end

  // Upper stage-1 bits are intentionally dropped when wrapping.
  if (OUT_WIDTH <= IN_WIDTH) begin : g_wrap
    logic unused_s1_hi;
    assign unused_s1_hi = ^s1_data[IN_WIDTH:OUT_WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      shift_reg <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= acc;
      s1_data   <= t;
      s1_last   <= acc && last_c;
      out_valid <= s1_valid;
      out_data  <= conv;
      out_last  <= s1_valid && s1_last;
      out_sat   <= s1_valid && conv_sat;
      if (acc) begin
        idx <= last_c ? '0 : idx + IDXW'(1);
        if (idx == '0) begin
          shift_reg <= shift_clamped;
        end
      end
    end
  end

endmodule

// File: tb/tb_ss_descale.sv
// Self-checking bench for ss_descale: directed test-plan steps plus randomized blocks
// scored against an arithmetic reference model; honours SS_DESCALE_SAT_EN.
module tb_ss_descale;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 12;
  localparam int MAX_SH = 5;
  localparam int BLK    = 8;
  localparam int SHW    = $clog2(MAX_SH + 1);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [SHW-1:0]   in_shift;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_sat;

  ss_descale #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .MAX_SHIFT(MAX_SH),
    .BLOCK_LEN(BLK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    int last;
    int sat;
    int acyc;
  } exp_t;

  exp_t exp_q[$];
  int   got_q[$];
  int   got_sat_q[$];
  int   got_last_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_lat  = 1'b0;
  int bp_mode  = 0;
  int pos      = 0;
  int bshift   = 0;
  bit prev_stall = 1'b0;
  int prev_data, prev_last, prev_sat;
  int m_y, m_sat;
  exp_t m_e;

  int round_in[8]  = '{3, -3, 5, 0, 1, -1, 7, -7};
  int round_out[8] = '{2, -1, 3, 0, 1, 0, 4, -3};
  int bp_pat[6]    = '{1, 0, 0, 1, 0, 1};

  task automatic check_output(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: exact floor((x + half) / 2^s), then clamp or wrap to OUT_W bits.
  function automatic void ref_model(input int x, input int s, output int y, output int sat);
    longint d, num, t, m;
    d   = longint'(1) << s;
    num = longint'(x) + ((s > 0) ? d / 2 : 0);
    t   = (num >= 0) ? num / d : -((-num + d - 1) / d);
    m   = longint'(1) << OUT_W;
    sat = 0;
`ifdef SS_DESCALE_SAT_EN
    if (t > m / 2 - 1) begin
      y = int'(m / 2 - 1); sat = 1;
    end else if (t < -(m / 2)) begin
      y = int'(-(m / 2)); sat = 1;
    end else begin
      y = int'(t);
    end
`else
    y = int'(((t % m) + m) % m);
    if (y >= int'(m / 2)) y -= int'(m);
`endif
  endfunction

  // Monitor: handshake rules, stall stability, scoreboard and latency.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      pos        = 0;
      prev_stall = 1'b0;
    end else begin
      check_output("in_ready_rule", int'(in_ready), int'(out_ready || !out_valid));
      if (prev_stall) begin
        check_output("stall_valid", int'(out_valid), 1);
        check_output("stall_data", int'($signed(out_data)), prev_data);
        check_output("stall_last", int'(out_last), prev_last);
        check_output("stall_sat", int'(out_sat), prev_sat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_output", int'(out_valid), 0);
        end else begin
          m_e = exp_q.pop_front();
          check_output("out_data", int'($signed(out_data)), m_e.data);
          check_output("out_last", int'(out_last), m_e.last);
          check_output("out_sat", int'(out_sat), m_e.sat);
          if (chk_lat) check_output("latency", cyc - m_e.acyc, 2);
        end
        got_q.push_back(int'($signed(out_data)));
        got_sat_q.push_back(int'(out_sat));
        got_last_q.push_back(int'(out_last));
      end
      if (in_valid && in_ready) begin
        if (pos == 0) bshift = (int'(in_shift) > MAX_SH) ? MAX_SH : int'(in_shift);
        ref_model(int'($signed(in_data)), bshift, m_y, m_sat);
        m_e.data = m_y;
        m_e.last = (pos == BLK - 1) ? 1 : 0;
        m_e.sat  = m_sat;
        m_e.acyc = cyc;
        exp_q.push_back(m_e);
        pos = (pos + 1) % BLK;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'($signed(out_data));
      prev_last  = int'(out_last);
      prev_sat   = int'(out_sat);
    end
  end

  // Downstream ready pattern generator.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1) begin
        out_ready = bp_pat[k][0];
        k = (k + 1) % 6;
      end else if (bp_mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic apply_stimulus(input int data, input int shift);
    int w = 0;
    in_valid = 1'b1;
    in_data  = data[IN_W-1:0];
    in_shift = shift[SHW-1:0];
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check_output("accept_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_output("drain", exp_q.size(), 0);
  endtask

  task automatic clear_got();
    got_q.delete();
    got_sat_q.delete();
    got_last_q.delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_data", int'(out_data), 0);
    check_output("rst_out_last", int'(out_last), 0);
    check_output("rst_out_sat", int'(out_sat), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    chk_lat = 1'b1;

    $display("[TB] rounding block, shift 1");
    clear_got();
    for (int i = 0; i < 8; i++) apply_stimulus(round_in[i], 1);
    wait_drain();
    check_output("round_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check_output("round_value", got_q[i], round_out[i]);
      check_output("round_last", got_last_q[i], (i == 7) ? 1 : 0);
    end

    $display("[TB] shift capture, mid-block in_shift toggled");
    clear_got();
    for (int i = 0; i < 8; i++) apply_stimulus(5, (i == 0) ? 2 : int'($urandom_range(0, 7)));
    for (int i = 0; i < 8; i++) apply_stimulus(5, (i == 0) ? 0 : int'($urandom_range(1, 7)));
    wait_drain();
    check_output("capture_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check_output("capture_value", got_q[i], (i < 8) ? 1 : 5);

    $display("[TB] saturation boundary, shift 2");
    clear_got();
    apply_stimulus(16384, 2);
    apply_stimulus(-16384, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0);
    wait_drain();
    check_output("sat_count", got_q.size(), 8);
    if (got_q.size() >= 2) begin
`ifdef SS_DESCALE_SAT_EN
      check_output("sat_pos", got_q[0], 2047);
      check_output("sat_neg", got_q[1], -2048);
      check_output("sat_flag_pos", got_sat_q[0], 1);
      check_output("sat_flag_neg", got_sat_q[1], 1);
`else
      check_output("wrap_pos", got_q[0], 0);
      check_output("wrap_neg", got_q[1], 0);
      check_output("wrap_flag_pos", got_sat_q[0], 0);
      check_output("wrap_flag_neg", got_sat_q[1], 0);
`endif
    end

    $display("[TB] shift clamp, in_shift 7 with MAX_SHIFT 5");
    clear_got();
    apply_stimulus(100, 7);
    for (int i = 0; i < 7; i++) apply_stimulus(100, 0);
    wait_drain();
    check_output("clamp_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_output("clamp_value", got_q[i], 3);

    $display("[TB] backpressure pattern over 3 random blocks");
    chk_lat = 1'b0;
    bp_mode = 1;
    clear_got();
    for (int i = 0; i < 3 * BLK; i++) begin
      r = int'($urandom);
      apply_stimulus(r, int'($urandom_range(0, 7)));
    end
    wait_drain();
    bp_mode = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check_output("bp_count", got_q.size(), 3 * BLK);

    $display("[TB] reset mid-block");
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(40 + i, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("midrst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check_output("midrst_s1_flushed", int'(out_valid), 0);
    clear_got();
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 4000)) - 2000;
      apply_stimulus(r, (i == 0) ? 3 : int'($urandom_range(0, 7)));
    end
    wait_drain();
    check_output("midrst_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_last_q.size(); i++)
      check_output("midrst_last", got_last_q[i], (i == 7) ? 1 : 0);

    $display("[TB] random blocks with random gaps and random ready");
    chk_lat = 1'b0;
    bp_mode = 2;
    clear_got();
    for (int i = 0; i < 4 * BLK; i++) begin
      r = int'($urandom);
      apply_stimulus(r, int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_drain();
    bp_mode = 0;
    check_output("random_count", got_q.size(), 4 * BLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
